ramp_pulse_checker: RTL
=======================

# ramp_pulse_checker

Receive-side checker for the full-level flag driven by the fill/drain ramp generator. The generator's flag protocol is fixed: sig high for exactly 2 consecutive cycles, then low for exactly 2·N cycles, repeating with a rising-edge-to-rising-edge period of 2·N+2 cycles. This block sits on the same clock as the generator, measures every high and low run against that protocol, and reports lock, protocol errors and a count of good pulses. It is the consumer end of the flag interface and is used both in-system and as a formal/simulation monitor.

## Interface
- N, 400000, ramp full level; expected low run 2·N, period 2·N+2
- RUN_W, 20, run-length counter width; must satisfy 2^RUN_W > 2·N+1
- CNT_W, 16, good-pulse counter width
- clk  in  1  clock; all state updated on posedge
- rst  in  1  reset; asynchronous, active-high
- sig_in  in  1  full-level flag from the ramp generator, same clock domain, no synchronizer
- lock  out  1  high while the checker is tracking a valid flag sequence
- err  out  1  protocol-violation indication (pulse or sticky, see Configuration)
- err_code  out  2  last violation: 0 none, 1 bad high run, 2 low run short, 3 low run long
- pulse_cnt  out  CNT_W  number of good pulses since reset, saturating at all-ones

## Operation
- Reset: lock=0, err=0, err_code=0, pulse_cnt=0, state SEARCH, run counter 0, previous-sample register=1 (a flag already high at reset is not a rising edge).
- Rising edge = sig_in=1 with previous sample 0.
- States:
  - SEARCH: wait for rising edge -> HIGH, run=1.
  - HIGH: sig_in=1 -> run+1; a 3rd consecutive high sample -> error code 1. sig_in=0 with run==2 -> LOW, run=1; with run==1 -> error code 1.
  - LOW: sig_in=0 -> run+1; a low sample making run==2·N+1 -> error code 3 immediately (no waiting for the edge). Rising edge with run==2·N -> good pulse: pulse_cnt+1 (saturating), lock=1, -> HIGH, run=1. Rising edge with run<2·N -> error code 2.
  - ERROR (sticky build only): terminal until reset.
- Error action (non-sticky): err=1 for one cycle, err_code loaded, lock=0. Codes 1 and 3 -> SEARCH. Code 2: the offending rising sample starts a new HIGH run (run=1), so a re-synced generator is reacquired without losing an edge.
- First good pulse counts only after one full HIGH+LOW sequence is seen from a rising edge; lock rises with it.
- err_code holds its value until the next error or reset; a good pulse does not clear it.
- Run counter never wraps: max value reached is 2·N+1, by the RUN_W rule.

## Timing
- All outputs registered; the response to the sample at edge k appears after edge k.
- Latency from violating sample to err: 1 cycle.
- Latency from completing rising edge to pulse_cnt/lock update: 1 cycle.
- Reset asserted mid-run: all outputs return to reset values asynchronously; operation restarts in SEARCH after release.
- Simultaneous events: a good rising edge when pulse_cnt is saturated still sets lock and enters HIGH; the count stays at all-ones.

## Configuration
- RPC_STICKY_ERR_EN defined: on any violation, enter ERROR; err stays 1, lock 0, err_code frozen, pulse_cnt frozen, until rst.
- Not defined: err is a 1-cycle pulse and the checker resynchronizes as described in Operation; no ERROR state exists.

## Structure
- Package ramp_chk_pkg: state enum (SEARCH, HIGH, LOW, ERROR), err_code enum (ERR_NONE, ERR_HIGH, ERR_LOW_SHORT, ERR_LOW_LONG), constant functions for high length (2), low length (2·N) and period (2·N+2).
- One sub-module: run_counter (RUN_W bits, clear-to-1 and increment inputs, async reset), instantiated once.

## Test plan
- N=4, ideal sequence (2 high, 8 low) for 5 periods -> lock rises 1 cycle after 2nd rising edge, pulse_cnt=4 after 5th edge, err never asserted.
- N=4, one high run of 3 cycles after lock -> err on cycle after 3rd high sample, err_code=1, lock=0; relock after next two good edges.
- N=4, low run of 6 then rising edge -> err_code=2, that edge restarts HIGH; following good period gives pulse_cnt+1 and lock=1.
- N=4, sig_in held low after lock -> err exactly after 9th low sample, err_code=3, state SEARCH.
- sig_in=1 during and after reset release -> no rising edge detected until a low sample followed by high; rst pulse mid-LOW clears pulse_cnt and lock immediately.
- RPC_STICKY_ERR_EN build, N=4, inject code-2 violation -> err stays 1 and pulse_cnt frozen across 3 further good periods until rst.

Source files
------------

// File: rtl/ramp_pulse_checker_pkg.sv
// ramp_chk_pkg: shared types and protocol-length helpers for the
// ramp_pulse_checker full-level flag monitor.
package ramp_chk_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    HIGH   = 2'd1,
    LOW    = 2'd2,
    ERROR  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_HIGH      = 2'd1,
    ERR_LOW_SHORT = 2'd2,
    ERR_LOW_LONG  = 2'd3
  } err_code_t;

  // Number of consecutive high samples in one flag pulse.
  function automatic int unsigned high_len();
    return 2;
  endfunction

  // Number of consecutive low samples between pulses for ramp level n.
  function automatic int unsigned low_len(input int unsigned n);
    return 2 * n;
  endfunction

  // Rising-edge-to-rising-edge period for ramp level n.
  function automatic int unsigned period_len(input int unsigned n);
    return 2 * n + 2;
  endfunction

endpackage

// File: rtl/ramp_pulse_checker_if.sv
// ramp_pulse_checker_if: flag input plus checker status outputs.
// master = flag source / status observer, slave = the checker.
interface ramp_pulse_checker_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             sig_in;
  logic             lock;
  logic             err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] pulse_cnt;

  modport master (output sig_in, input lock, input err, input err_code, input pulse_cnt);
  modport slave  (input sig_in, output lock, output err, output err_code, output pulse_cnt);
endinterface

// File: rtl/ramp_pulse_checker_run_counter.sv
// run_counter: length of the current high/low run. Clear loads 1 because
// the sample that starts a run is already the run's first sample.
module run_counter #(
  parameter int unsigned RUN_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [RUN_W-1:0] run
);

  // Run length register: clear-to-1 has priority over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      run <= '0;
    else if (clr) run <= RUN_W'(1);
    else if (inc) run <= run + 1'b1;
  end

endmodule

// File: rtl/ramp_pulse_checker.sv
// ramp_pulse_checker: measures high/low runs of the ramp generator's
// full-level flag (2 high, 2*N low), reports lock, errors and good pulses.
// Build option: RPC_STICKY_ERR_EN makes any violation terminal until rst.
module ramp_pulse_checker
  import ramp_chk_pkg::*;
#(
  parameter int unsigned N     = 400000,
  parameter int unsigned RUN_W = 20,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  ramp_pulse_checker_if.slave  bus
);

  localparam logic [RUN_W-1:0] HIGH_RUN = RUN_W'(high_len());
  localparam logic [RUN_W-1:0] LOW_RUN  = RUN_W'(low_len(N));

  state_t           state_q, state_d;
  logic             prev_q;
  logic             lock_q, lock_d;
  logic             err_q, err_d;
  err_code_t        code_q, code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clr, inc;
  logic             viol;
  err_code_t        viol_code;
  logic [RUN_W-1:0] run;
  logic             rise;

  assign rise = bus.sig_in & ~prev_q;

  run_counter #(.RUN_W(RUN_W)) u_run (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (inc),
    .run (run)
  );

  // State, previous sample and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEARCH;
      prev_q  <= 1'b1;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= bus.sig_in;
      lock_q  <= lock_d;
      err_q   <= err_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  // Run classification, next state and next output values.
  always_comb begin
    state_d   = state_q;
    lock_d    = lock_q;
    err_d     = 1'b0;
    code_d    = code_q;
    cnt_d     = cnt_q;
    clr       = 1'b0;
    inc       = 1'b0;
    viol      = 1'b0;
    viol_code = ERR_NONE;

    case (state_q)
      SEARCH: begin
        if (rise) begin
          state_d = HIGH;
          clr     = 1'b1;
        end
      end
      HIGH: begin
        if (bus.sig_in) begin
          if (run == HIGH_RUN) begin
            viol      = 1'b1;
            viol_code = ERR_HIGH;
          end else begin
            inc = 1'b1;
          end
        end else if (run == HIGH_RUN) begin
          state_d = LOW;
          clr     = 1'b1;
        end else begin
          viol      = 1'b1;
          viol_code = ERR_HIGH;
        end
      end
      LOW: begin
        // LOW is only entered on a low sample, so any high sample here is a rising edge.
        if (!bus.sig_in) begin
          if (run == LOW_RUN) begin
            viol      = 1'b1;
            viol_code = ERR_LOW_LONG;
          end else begin
            inc = 1'b1;
          end
        end else if (run == LOW_RUN) begin
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          lock_d  = 1'b1;
          state_d = HIGH;
          clr     = 1'b1;
        end else begin
          viol      = 1'b1;
          viol_code = ERR_LOW_SHORT;
        end
      end
`ifdef RPC_STICKY_ERR_EN
      ERROR: begin
        err_d = 1'b1;
      end
`endif
      default: begin
        state_d = SEARCH;
      end
    endcase

    if (viol) begin
      err_d  = 1'b1;
      code_d = viol_code;
      lock_d = 1'b0;
      inc    = 1'b0;
`ifdef RPC_STICKY_ERR_EN
      state_d = ERROR;
      clr     = 1'b0;
`else
      // A short low run ends on a real rising edge; keep it as the start of a new pulse.
      if (viol_code == ERR_LOW_SHORT) begin
        state_d = HIGH;
        clr     = 1'b1;
      end else begin
        state_d = SEARCH;
        clr     = 1'b0;
      end
`endif
    end
  end

  assign bus.lock      = lock_q;
  assign bus.err       = err_q;
  assign bus.err_code  = code_q;
  assign bus.pulse_cnt = cnt_q;

endmodule
